xoodyak_absorb_ctrl: RTL and testbench
======================================

# xoodyak_absorb_ctrl

Sequential Xoodyak AbsorbAny engine. It takes a message (associated data, nonce or hash input) as a stream of rate-sized blocks over a valid/ready handshake. Before each Down it hands the state to the shared permutation core, then applies Down(X_i, C_d), including byte-granular padding for a short final block. It sits between the top-level cyclist controller and the Xoodoo permutation core, and replaces the fixed single-block, 352-bit combinational absorb path.

## Interface
Parameters:
- RATE_BYTES, 44, absorb rate in bytes. Use 44 for keyed mode and 16 for hash mode. Legal range 1..46.
- CNT_W, $clog2(RATE_BYTES+1), width of the byte-count field.

Ports:
- eph1, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- start, in, 1, begin an absorb. Accepted only in IDLE.
- state_in, in, 384, cyclist state at start.
- phase_up_in, in, 1, 1 = state already in Up phase, so the first permutation is skipped.
- cd_first, in, 8, domain constant for the first block (0x03 = AD). Later blocks use 0x00.
- blk_valid, in, 1, data block offered.
- blk_ready, out, 1, engine can accept a block.
- blk_data, in, 8*RATE_BYTES, block data. Byte 0 is in the MSBs.
- blk_nbytes, in, CNT_W, number of valid bytes, 0..RATE_BYTES.
- blk_last, in, 1, final block of the message.
- perm_start, out, 1, one-cycle request to the permutation core.
- perm_state_out, out, 384, state sent to the core. Held stable while waiting.
- perm_done, in, 1, one-cycle completion from the core.
- perm_state_in, in, 384, permuted state. Valid only with perm_done.
- absorbed_state, out, 384, final state. Held after done.
- done, out, 1, one-cycle pulse at completion.
- busy, out, 1, high in any state other than IDLE.
- proto_err, out, 1, sticky. Set when a non-last block has blk_nbytes != RATE_BYTES or any block has blk_nbytes > RATE_BYTES. Cleared by reset or an accepted start.

## Operation
- Byte i of the 384-bit state occupies bits [383-8i -: 8].
- FSM states: IDLE, PERM_REQ, PERM_WAIT, DATA, DONE.
- IDLE:
  - On start, latch state_in into st_r and cd_first into cd_r, and clear proto_err.
  - Go to DATA if phase_up_in=1, else to PERM_REQ.
- PERM_REQ: assert perm_start for one cycle, with perm_state_out = st_r. Then go to PERM_WAIT.
- PERM_WAIT:
  - Wait any number of cycles for perm_done.
  - On perm_done, st_r <= perm_state_in and go to DATA.
- DATA:
  - blk_ready=1. When blk_valid & blk_ready, apply Down in one cycle with n = min(blk_nbytes, RATE_BYTES):
    - state byte i ^= blk_data byte i, for i < n;
    - byte n ^= 0x01;
    - byte 47 ^= cd_r.
  - Then cd_r <= 0x00.
  - If blk_last, go to DONE. Otherwise go to PERM_REQ.
- DONE:
  - absorbed_state <= updated state and done=1 for one cycle. Then return to IDLE.
  - absorbed_state holds until the next done or reset.
- blk_nbytes=0 on the last block is legal: padding only (empty message, or a message that is an exact multiple of the rate).
- If blk_nbytes exceeds RATE_BYTES, set proto_err and use n = RATE_BYTES. The padding byte is then byte RATE_BYTES.
- Data bytes at index >= n are masked and have no effect.
- start while busy is ignored.
- perm_done outside PERM_WAIT is ignored.
- blk_valid outside DATA is not consumed.

## Timing
- Reset takes priority over everything, including mid-operation:
  - FSM goes to IDLE; st_r, cd_r and absorbed_state go to 0.
  - All outputs are 0: blk_ready, perm_start, done, busy, proto_err, and perm_state_out = 0.
- Single block with phase_up_in=1 and the block valid when DATA is entered: done is high 2 cycles after start (start at edge, accept, DONE).
- Each extra block costs 2 cycles plus the permutation latency: PERM_REQ (1 cycle), PERM_WAIT (core latency, at least 1 cycle), DATA (at least 1 cycle).
- blk_ready is a registered-state decode. It does not depend combinationally on blk_valid.
- perm_state_out = st_r whenever the FSM is in PERM_REQ or PERM_WAIT, and 0 otherwise.
- The Down XOR path (384-bit) is the only wide combinational path. It is registered into st_r.

## Structure
- Package xoodyak_pkg holds:
  - STATE_W=384 and STATE_BYTES=48;
  - localparams CD_ABSORB_AD=8'h03, CD_NONE=8'h00, PAD_BYTE=8'h01;
  - the FSM enum absorb_st_t.
- Sub-module xoodyak_down (combinational), with parameter RATE_BYTES. Inputs: state, data, n, cd. Output: the new state. It builds a per-byte mask from n. It is reused later by the squeeze/crypt blocks.
- The top module holds the FSM, st_r, cd_r, the proto_err flag and the output registers.

## Test plan
- Empty AD: phase_up_in=0, cd_first=0x03, one block with nbytes=0 and last=1, perm core returns P → absorbed_state = P ^ (byte0 0x01, byte47 0x03); exactly one perm_start; done pulses once.
- Full block, phase_up_in=1, RATE_BYTES=44, data=0xAA..AA, nbytes=44, last=1 → no perm_start; byte44 ^= 0x01, byte47 ^= 0x03; done 2 cycles after start.
- Three blocks (44, 44, 5 bytes), core latency 12 → 3 perm_starts; cd applied only on the first Down; the third block pads byte 5; blk_valid held high is consumed only in DATA.
- RATE_BYTES=16 hash instance: 17-byte message as 16+1 → padding at byte 16 then byte 1; cd_first=0x03 then 0x00.
- Protocol error: non-last block with nbytes=10 → proto_err=1 and stays high through done; cleared by the next start.
- Reset asserted in PERM_WAIT and in DATA → next cycle busy=0, blk_ready=0, absorbed_state=0; a later perm_done is ignored; a fresh start completes correctly.

Source files
------------

// File: rtl/xoodyak_pkg.sv
// -----------------------------------------------------------------------------
// xoodyak_pkg
// Shared constants and types for the Xoodyak cyclist datapath blocks:
// state geometry, domain/padding constants and the absorb FSM encoding.
// -----------------------------------------------------------------------------
package xoodyak_pkg;

   localparam int STATE_W     = 384;
   localparam int STATE_BYTES = 48;

   localparam logic [7:0] CD_ABSORB_AD = 8'h03;
   localparam logic [7:0] CD_NONE      = 8'h00;
   localparam logic [7:0] PAD_BYTE     = 8'h01;

   typedef enum logic [2:0] {
      IDLE,
      PERM_REQ,
      PERM_WAIT,
      DATA,
      DONE
   } absorb_st_t;

endpackage

// File: rtl/xoodyak_down.sv
// -----------------------------------------------------------------------------
// xoodyak_down
// Combinational Down(X, Cd) on the 384-bit Xoodoo state.
//   state     : current state, byte i at bits [383-8i -: 8]
//   data      : RATE_BYTES-byte block, byte 0 in the MSBs
//   n         : number of data bytes to absorb, caller keeps n <= RATE_BYTES
//   cd        : domain constant XORed into byte 47
//   new_state : state ^ data[0..n-1] ^ (0x01 at byte n) ^ (cd at byte 47)
// -----------------------------------------------------------------------------
module xoodyak_down
   import xoodyak_pkg::*;
#(
   parameter int RATE_BYTES = 44,
   parameter int CNT_W      = $clog2(RATE_BYTES + 1)
) (
   input  logic [STATE_W-1:0]      state,
   input  logic [8*RATE_BYTES-1:0] data,
   input  logic [CNT_W-1:0]        n,
   input  logic [7:0]              cd,
   output logic [STATE_W-1:0]      new_state
);

   // Data aligned to the state byte numbering; bytes past the rate are zero.
   logic [STATE_W-1:0] data_ext;
   assign data_ext = {data, {(STATE_W - 8*RATE_BYTES){1'b0}}};

   always_comb begin
      new_state = state;
      for (int i = 0; i < STATE_BYTES; i++) begin
         if (i < int'(n)) begin
            new_state[STATE_W-1-8*i -: 8] ^= data_ext[STATE_W-1-8*i -: 8];
         end
         if (i == int'(n)) begin
            new_state[STATE_W-1-8*i -: 8] ^= PAD_BYTE;
         end
      end
      new_state[7:0] ^= cd;
   end

endmodule

// File: rtl/xoodyak_absorb_ctrl.sv
// -----------------------------------------------------------------------------
// xoodyak_absorb_ctrl
// Sequential Xoodyak AbsorbAny engine. Takes rate-sized blocks over a
// valid/ready handshake, runs the shared permutation core before every Down
// (except the first when the state is already in the Up phase) and applies
// Down with byte-granular padding.
//   eph1 / reset           : clock, synchronous active-high reset
//   start, state_in,
//   phase_up_in, cd_first  : absorb request and its initial context (IDLE only)
//   blk_*                  : block stream, blk_ready is a pure state decode
//   perm_start/perm_done,
//   perm_state_out/_in     : request/response to the permutation core
//   absorbed_state, done   : result (held) and one-cycle completion pulse
//   busy, proto_err        : status; proto_err is sticky until reset/start
// -----------------------------------------------------------------------------
module xoodyak_absorb_ctrl
   import xoodyak_pkg::*;
#(
   parameter int RATE_BYTES = 44,
   parameter int CNT_W      = $clog2(RATE_BYTES + 1)
) (
   input  logic                    eph1,
   input  logic                    reset,
   input  logic                    start,
   input  logic [STATE_W-1:0]      state_in,
   input  logic                    phase_up_in,
   input  logic [7:0]              cd_first,
   input  logic                    blk_valid,
   output logic                    blk_ready,
   input  logic [8*RATE_BYTES-1:0] blk_data,
   input  logic [CNT_W-1:0]        blk_nbytes,
   input  logic                    blk_last,
   output logic                    perm_start,
   output logic [STATE_W-1:0]      perm_state_out,
   input  logic                    perm_done,
   input  logic [STATE_W-1:0]      perm_state_in,
   output logic [STATE_W-1:0]      absorbed_state,
   output logic                    done,
   output logic                    busy,
   output logic                    proto_err
);

   localparam logic [CNT_W-1:0] RATE_N = CNT_W'(RATE_BYTES);

   absorb_st_t         state_r, state_nxt;
   logic [STATE_W-1:0] st_r;
   logic [7:0]         cd_r;
   logic [STATE_W-1:0] down_state;
   logic [CNT_W-1:0]   n_eff;
   logic               accept;
   logic               blk_bad;

   assign accept  = blk_valid && (state_r == DATA);
   // Oversized counts are clamped so the pad lands on byte RATE_BYTES.
   assign n_eff   = (blk_nbytes > RATE_N) ? RATE_N : blk_nbytes;
   assign blk_bad = (blk_nbytes > RATE_N) || (!blk_last && (blk_nbytes != RATE_N));

   xoodyak_down #(
      .RATE_BYTES (RATE_BYTES),
      .CNT_W      (CNT_W)
   ) u_down (
      .state     (st_r),
      .data      (blk_data),
      .n         (n_eff),
      .cd        (cd_r),
      .new_state (down_state)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge eph1) begin
      if (reset) state_r <= IDLE;
      else       state_r <= state_nxt;
   end

   // NOTE: every output of this block gets a default first; a missing
   // assignment on any path would otherwise infer a latch.
   always_comb begin
      state_nxt      = state_r;
      blk_ready      = 1'b0;
      perm_start     = 1'b0;
      done           = 1'b0;
      busy           = 1'b1;
      perm_state_out = '0;
      case (state_r)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = phase_up_in ? DATA : PERM_REQ;
         end
         PERM_REQ: begin
            perm_start     = 1'b1;
            perm_state_out = st_r;
            state_nxt      = PERM_WAIT;
         end
         PERM_WAIT: begin
            perm_state_out = st_r;
            if (perm_done) state_nxt = DATA;
         end
         DATA: begin
            blk_ready = 1'b1;
            if (blk_valid) state_nxt = blk_last ? DONE : PERM_REQ;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the wide state registers are reset explicitly because the result
   // port must read zero after reset, not just the control path.
   always_ff @(posedge eph1) begin
      if (reset) begin
         st_r           <= '0;
         cd_r           <= CD_NONE;
         absorbed_state <= '0;
         proto_err      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  st_r      <= state_in;
                  cd_r      <= cd_first;
                  proto_err <= 1'b0;
               end
            end
            PERM_WAIT: begin
               if (perm_done) st_r <= perm_state_in;
            end
            DATA: begin
               if (accept) begin
                  st_r <= down_state;
                  cd_r <= CD_NONE;
                  if (blk_bad) proto_err <= 1'b1;
                  // Loaded on the final Down so the result is already
                  // valid in the cycle done is high.
                  if (blk_last) absorbed_state <= down_state;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_xoodyak_absorb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_xoodyak_absorb_ctrl
// Directed bench for the keyed (44-byte) and hash (16-byte) absorb instances.
// The bench plays the permutation core with fixed response states.
// -----------------------------------------------------------------------------
module tb_xoodyak_absorb_ctrl;

   logic eph1 = 1'b0;
   always #5 eph1 = ~eph1;

   logic         reset, start, start16, phase_up_in;
   logic [383:0] state_in, perm_state_in;
   logic [7:0]   cd_first;
   logic         blk_valid, blk_last, perm_done;
   logic [351:0] blk_data;
   logic [5:0]   blk_nbytes;
   logic [127:0] blk_data16;
   logic [4:0]   blk_nbytes16;

   logic         a_blk_ready, a_perm_start, a_done, a_busy, a_proto_err;
   logic [383:0] a_perm_state_out, a_absorbed;
   logic         h_blk_ready, h_perm_start, h_done, h_busy, h_proto_err;
   logic [383:0] h_perm_state_out, h_absorbed;

   int n_checks = 0;
   int n_fail   = 0;
   int perm_cnt = 0;
   int done_cnt = 0;
   int pc0, dc0;

   logic [383:0] s0, s1, s2, s3, s4, s5, p1, pa, pb, pc, q1, q2, p5, p6, x1, x2, xe;
   logic [351:0] d1, d2, d3, d4, d5, d6;
   logic [127:0] e1, e2;

   xoodyak_absorb_ctrl #(.RATE_BYTES(44)) dut (
      .eph1           (eph1),
      .reset          (reset),
      .start          (start),
      .state_in       (state_in),
      .phase_up_in    (phase_up_in),
      .cd_first       (cd_first),
      .blk_valid      (blk_valid),
      .blk_ready      (a_blk_ready),
      .blk_data       (blk_data),
      .blk_nbytes     (blk_nbytes),
      .blk_last       (blk_last),
      .perm_start     (a_perm_start),
      .perm_state_out (a_perm_state_out),
      .perm_done      (perm_done),
      .perm_state_in  (perm_state_in),
      .absorbed_state (a_absorbed),
      .done           (a_done),
      .busy           (a_busy),
      .proto_err      (a_proto_err)
   );

   xoodyak_absorb_ctrl #(.RATE_BYTES(16)) dut16 (
      .eph1           (eph1),
      .reset          (reset),
      .start          (start16),
      .state_in       (state_in),
      .phase_up_in    (phase_up_in),
      .cd_first       (cd_first),
      .blk_valid      (blk_valid),
      .blk_ready      (h_blk_ready),
      .blk_data       (blk_data16),
      .blk_nbytes     (blk_nbytes16),
      .blk_last       (blk_last),
      .perm_start     (h_perm_start),
      .perm_state_out (h_perm_state_out),
      .perm_done      (perm_done),
      .perm_state_in  (perm_state_in),
      .absorbed_state (h_absorbed),
      .done           (h_done),
      .busy           (h_busy),
      .proto_err      (h_proto_err)
   );

   always @(posedge eph1) begin
      if (a_perm_start) perm_cnt <= perm_cnt + 1;
      if (a_done)       done_cnt <= done_cnt + 1;
   end

   // Single byte v placed at state byte i.
   function automatic logic [383:0] byte_at(input int i, input logic [7:0] v);
      byte_at = 384'(v) << (8 * (47 - i));
   endfunction

   task automatic tick();
      @(posedge eph1);
      #1;
   endtask

   task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Entered in the PERM_REQ cycle; returns in the first DATA cycle.
   task automatic core_respond(input logic [383:0] p, input int lat);
      tick();
      for (int k = 1; k < lat; k++) tick();
      perm_done     = 1'b1;
      perm_state_in = p;
      tick();
      perm_done     = 1'b0;
      perm_state_in = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      s0 = {12{32'h0123_4567}};  s1 = {12{32'h89AB_CDEF}};
      s2 = {12{32'h0F1E_2D3C}};  s3 = {12{32'h5A69_7887}};
      s4 = {12{32'hC0DE_F00D}};  s5 = {12{32'h7654_3210}};
      p1 = {12{32'h1357_9BDF}};  pa = {12{32'h2468_ACE0}};
      pb = {12{32'hFEDC_BA98}};  pc = {12{32'h3141_5926}};
      q1 = {12{32'h2718_2818}};  q2 = {12{32'h1122_3344}};
      p5 = {12{32'h6655_4433}};  p6 = {12{32'h9988_7766}};
      d1 = {11{32'h1122_3344}};  d2 = {11{32'h5566_7788}};
      d3 = {11{32'h99AA_BBCC}};  d4 = {11{32'hA1B2_C3D4}};
      d5 = {11{32'hE5F6_0718}};  d6 = {11{32'h4D5E_6F70}};
      e1 = {4{32'hCAFE_BABE}};   e2 = {4{32'h7F00_FF00}};

      reset = 1'b1; start = 1'b0; start16 = 1'b0; phase_up_in = 1'b0;
      state_in = '0; perm_state_in = '0; cd_first = 8'h00;
      blk_valid = 1'b0; blk_last = 1'b0; perm_done = 1'b0;
      blk_data = '0; blk_nbytes = '0; blk_data16 = '0; blk_nbytes16 = '0;
      tick(); tick();
      reset = 1'b0;

      // Reset state
      check("rst_busy", a_busy, 0);
      check("rst_ready", a_blk_ready, 0);
      check("rst_perm_start", a_perm_start, 0);
      check("rst_pso", a_perm_state_out, 0);
      check("rst_absorbed", a_absorbed, 0);
      check("rst_proto", a_proto_err, 0);
      check("rst_busy16", h_busy, 0);

      // Empty AD: one permutation, padding only
      pc0 = perm_cnt; dc0 = done_cnt;
      state_in = s0; cd_first = 8'h03; phase_up_in = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      check("t1_perm_start", a_perm_start, 1);
      check("t1_pso", a_perm_state_out, s0);
      check("t1_ready_req", a_blk_ready, 0);
      core_respond(p1, 3);
      check("t1_ready", a_blk_ready, 1);
      blk_valid = 1'b1; blk_data = {11{32'hDEAD_BEEF}}; blk_nbytes = 6'd0; blk_last = 1'b1;
      tick(); blk_valid = 1'b0;
      check("t1_done", a_done, 1);
      check("t1_absorbed", a_absorbed, p1 ^ byte_at(0, 8'h01) ^ byte_at(47, 8'h03));
      tick();
      check("t1_done_low", a_done, 0);
      check("t1_idle", a_busy, 0);
      check("t1_perm_cnt", 384'(perm_cnt - pc0), 1);
      check("t1_done_cnt", 384'(done_cnt - dc0), 1);

      // Full block, already in Up phase: no permutation, done 2 cycles after start
      pc0 = perm_cnt;
      state_in = s1; phase_up_in = 1'b1; start = 1'b1;
      blk_valid = 1'b1; blk_data = {44{8'hAA}}; blk_nbytes = 6'd44; blk_last = 1'b1;
      tick(); start = 1'b0;
      check("t2_ready", a_blk_ready, 1);
      check("t2_done_early", a_done, 0);
      tick(); blk_valid = 1'b0;
      check("t2_done", a_done, 1);
      check("t2_absorbed", a_absorbed,
            s1 ^ {{44{8'hAA}}, 32'h0} ^ byte_at(44, 8'h01) ^ byte_at(47, 8'h03));
      tick();
      check("t2_perm_cnt", 384'(perm_cnt - pc0), 0);

      // Three blocks (44, 44, 5), core latency 12, blk_valid held high
      pc0 = perm_cnt;
      x1 = pa ^ {d1, 32'h0} ^ byte_at(44, 8'h01) ^ byte_at(47, 8'h03);
      x2 = pb ^ {d2, 32'h0} ^ byte_at(44, 8'h01);
      xe = pc ^ {d3[351 -: 40], 344'h0} ^ byte_at(5, 8'h01);
      state_in = s2; phase_up_in = 1'b0; cd_first = 8'h03; start = 1'b1;
      blk_valid = 1'b1; blk_data = d1; blk_nbytes = 6'd44; blk_last = 1'b0;
      tick(); start = 1'b0;
      core_respond(pa, 12);
      check("t3_ready1", a_blk_ready, 1);
      tick();
      check("t3_pso1", a_perm_state_out, x1);
      blk_data = d2;
      core_respond(pb, 12);
      tick();
      check("t3_pso2", a_perm_state_out, x2);
      blk_data = d3; blk_nbytes = 6'd5; blk_last = 1'b1;
      core_respond(pc, 12);
      tick(); blk_valid = 1'b0;
      check("t3_done", a_done, 1);
      check("t3_absorbed", a_absorbed, xe);
      check("t3_proto", a_proto_err, 0);
      tick();
      check("t3_perm_cnt", 384'(perm_cnt - pc0), 3);

      // Hash instance, 17-byte message as 16 + 1
      state_in = s3; phase_up_in = 1'b0; cd_first = 8'h03; start16 = 1'b1;
      tick(); start16 = 1'b0;
      check("t4_perm_start", h_perm_start, 1);
      core_respond(q1, 2);
      blk_valid = 1'b1; blk_data16 = e1; blk_nbytes16 = 5'd16; blk_last = 1'b0;
      tick();
      check("t4_pso", h_perm_state_out,
            q1 ^ {e1, 256'h0} ^ byte_at(16, 8'h01) ^ byte_at(47, 8'h03));
      blk_data16 = e2; blk_nbytes16 = 5'd1; blk_last = 1'b1;
      core_respond(q2, 1);
      tick(); blk_valid = 1'b0;
      check("t4_done", h_done, 1);
      check("t4_absorbed", h_absorbed, q2 ^ {e2[127 -: 8], 376'h0} ^ byte_at(1, 8'h01));
      check("t4_keyed_idle", a_busy, 0);
      tick();

      // Protocol error: short non-last block, then oversized last block
      state_in = s4; phase_up_in = 1'b1; cd_first = 8'h03; start = 1'b1;
      tick(); start = 1'b0;
      check("t5_proto_clear", a_proto_err, 0);
      blk_valid = 1'b1; blk_data = d4; blk_nbytes = 6'd10; blk_last = 1'b0;
      tick(); blk_valid = 1'b0;
      check("t5_proto_set", a_proto_err, 1);
      check("t5_pso", a_perm_state_out,
            s4 ^ {d4[351 -: 80], 304'h0} ^ byte_at(10, 8'h01) ^ byte_at(47, 8'h03));
      core_respond(p5, 2);
      blk_valid = 1'b1; blk_data = d5; blk_nbytes = 6'd50; blk_last = 1'b1;
      tick(); blk_valid = 1'b0;
      check("t5_done", a_done, 1);
      check("t5_absorbed", a_absorbed, p5 ^ {d5, 32'h0} ^ byte_at(44, 8'h01));
      tick();
      check("t5_proto_sticky", a_proto_err, 1);
      start = 1'b1;
      tick(); start = 1'b0;
      check("t5_proto_restart", a_proto_err, 0);

      // Reset while in DATA
      reset = 1'b1; tick(); reset = 1'b0;
      check("t6_data_busy", a_busy, 0);
      check("t6_data_ready", a_blk_ready, 0);
      check("t6_data_absorbed", a_absorbed, 0);

      // Reset while in PERM_WAIT, then a stray perm_done
      state_in = s5; phase_up_in = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      tick();
      check("t6_in_wait", a_perm_state_out, s5);
      reset = 1'b1; tick(); reset = 1'b0;
      check("t6_wait_busy", a_busy, 0);
      check("t6_wait_pso", a_perm_state_out, 0);
      perm_done = 1'b1; perm_state_in = p6;
      tick(); perm_done = 1'b0; perm_state_in = '0;
      check("t6_stray_done", a_busy, 0);
      check("t6_stray_ready", a_blk_ready, 0);

      // Fresh absorb after reset
      state_in = s5; phase_up_in = 1'b0; cd_first = 8'h03; start = 1'b1;
      tick(); start = 1'b0;
      check("t6_fresh_pso", a_perm_state_out, s5);
      core_respond(p6, 1);
      blk_valid = 1'b1; blk_data = d6; blk_nbytes = 6'd3; blk_last = 1'b1;
      tick(); blk_valid = 1'b0;
      check("t6_fresh_done", a_done, 1);
      check("t6_fresh_absorbed", a_absorbed,
            p6 ^ {d6[351 -: 24], 360'h0} ^ byte_at(3, 8'h01) ^ byte_at(47, 8'h03));
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
